// File: rtl/sync_fifo_pkt.sv
// sync_fifo_pkt: packet-aware single-clock FIFO in distributed RAM.
// Words are written with an end-of-packet flag. With PKT_MODE=1 a packet
// becomes readable only once its last word is accepted, and an in-flight
// packet can be discarded with wr_drop. With PKT_MODE=0 every accepted
// write is readable on the next cycle.
//
// Ports:
//   clk, arst            clock (rising edge), async active-high reset
//   din, din_last, we    write data, end-of-packet marker, write request
//   wr_drop              discard all uncommitted words (PKT_MODE=1)
//   re                   read request
//   wr_count, rd_count   occupied (committed+pending) / readable entries
//   full, empty          occupancy flags (empty registered)
//   almost_full/empty    registered threshold flags
//   wr_overflow          registered pulse: write refused (full or drop)
//   dout_comb            combinational head-of-FIFO data
//   dout, dout_last      registered read data and its last flag
module sync_fifo_pkt #(
    parameter int DWIDTH     = 16,
    parameter int AWIDTH     = 4,
    parameter int PKT_MODE   = 1,
    parameter int AFULL_THR  = 2**AWIDTH - 2,
    parameter int AEMPTY_THR = 1
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [DWIDTH-1:0] din,
    input  logic              din_last,
    input  logic              we,
    input  logic              wr_drop,
    input  logic              re,
    output logic [AWIDTH:0]   wr_count,
    output logic [AWIDTH:0]   rd_count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              wr_overflow,
    output logic [DWIDTH-1:0] dout_comb,
    output logic [DWIDTH-1:0] dout,
    output logic              dout_last
);

    localparam int              C_DEPTH  = 1 << AWIDTH;
    localparam bit              C_PKT    = (PKT_MODE != 0);
    localparam logic [AWIDTH:0] C_AFULL  = (AWIDTH+1)'(AFULL_THR);
    localparam logic [AWIDTH:0] C_AEMPTY = (AWIDTH+1)'(AEMPTY_THR);
    localparam logic [AWIDTH:0] C_ONE    = (AWIDTH+1)'(1);

    logic [DWIDTH:0]   r_mem [0:C_DEPTH-1];

    logic [AWIDTH-1:0] r_wr_addr, r_cm_addr, r_rd_addr;
    logic [AWIDTH:0]   r_pend, r_wr_count, r_rd_count;
    logic              r_empty, r_afull, r_aempty, r_overflow;
    logic [DWIDTH-1:0] r_dout;
    logic              r_dout_last;

    logic              w_full, w_drop, w_we_acc, w_re_acc, w_commit;
    logic [AWIDTH:0]   w_n_cm, w_dec, w_we_ext, w_re_ext;
    logic [AWIDTH:0]   w_wr_count_nxt, w_rd_count_nxt, w_pend_nxt;
    logic [AWIDTH-1:0] w_wr_addr_nxt, w_cm_addr_nxt;
    logic [DWIDTH:0]   w_rd_word;

    assign w_full    = r_wr_count[AWIDTH];
    assign w_rd_word = r_mem[r_rd_addr];

    always_comb begin
        w_drop   = C_PKT & wr_drop;
        w_we_acc = we & ~w_full & ~w_drop;
        w_re_acc = re & ~r_empty;
        w_we_ext = w_we_acc ? C_ONE : '0;
        w_re_ext = w_re_acc ? C_ONE : '0;
        w_commit = 1'b0;
        w_n_cm   = '0;
        if (C_PKT) begin
            w_commit = w_we_acc & din_last;
            // pend+1 rather than a pointer difference: a 16-word packet
            // leaves wr_addr == cm_addr, which pointers alone cannot resolve.
            if (w_commit)
                w_n_cm = r_pend + C_ONE;
        end else begin
            w_n_cm = w_we_ext;
        end
        w_dec = w_drop ? r_pend : '0;

        w_rd_count_nxt = r_rd_count + w_n_cm - w_re_ext;
        w_wr_count_nxt = r_wr_count + w_we_ext - w_re_ext - w_dec;

        w_pend_nxt = r_pend;
        if (!C_PKT || w_drop || w_commit)
            w_pend_nxt = '0;
        else if (w_we_acc)
            w_pend_nxt = r_pend + C_ONE;

        w_wr_addr_nxt = r_wr_addr;
        if (w_drop)
            w_wr_addr_nxt = r_cm_addr;
        else if (w_we_acc)
            w_wr_addr_nxt = r_wr_addr + 1'b1;

        if (C_PKT)
            w_cm_addr_nxt = w_commit ? r_wr_addr + 1'b1 : r_cm_addr;
        else
            w_cm_addr_nxt = w_wr_addr_nxt;
    end

    // RAM is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_we_acc)
            r_mem[r_wr_addr] <= {din_last, din};
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_wr_addr   <= '0;
            r_cm_addr   <= '0;
            r_rd_addr   <= '0;
            r_pend      <= '0;
            r_wr_count  <= '0;
            r_rd_count  <= '0;
            r_empty     <= 1'b1;
            r_afull     <= 1'b0;
            r_aempty    <= 1'b1;
            r_overflow  <= 1'b0;
            r_dout      <= '0;
            r_dout_last <= 1'b0;
        end else begin
            r_wr_addr  <= w_wr_addr_nxt;
            r_cm_addr  <= w_cm_addr_nxt;
            r_pend     <= w_pend_nxt;
            r_wr_count <= w_wr_count_nxt;
            r_rd_count <= w_rd_count_nxt;
            r_empty    <= (w_rd_count_nxt == '0);
            r_afull    <= (w_wr_count_nxt >= C_AFULL);
            r_aempty   <= (w_rd_count_nxt <= C_AEMPTY);
            r_overflow <= we & (w_full | w_drop);
            if (w_re_acc) begin
                r_rd_addr   <= r_rd_addr + 1'b1;
                r_dout      <= w_rd_word[DWIDTH-1:0];
                r_dout_last <= w_rd_word[DWIDTH];
            end
        end
    end

    assign wr_count     = r_wr_count;
    assign rd_count     = r_rd_count;
    assign full         = w_full;
    assign empty        = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign wr_overflow  = r_overflow;
    assign dout_comb    = w_rd_word[DWIDTH-1:0];
    assign dout         = r_dout;
    assign dout_last    = r_dout_last;

endmodule

// File: tb/tb_sync_fifo_pkt.sv
module tb_sync_fifo_pkt;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [15:0] din = '0;
    logic        din_last = 1'b0, we = 1'b0, wr_drop = 1'b0, re = 1'b0;

    logic [4:0]  wc1, rc1, wc0, rc0;
    logic        full1, empty1, af1, ae1, ov1, dl1;
    logic        full0, empty0, af0, ae0, ov0, dl0;
    logic [15:0] dc1, do1, dc0, do0;

    always #5 clk = ~clk;

    sync_fifo_pkt #(.DWIDTH(16), .AWIDTH(4), .PKT_MODE(1)) dut1 (
        .clk(clk), .arst(arst), .din(din), .din_last(din_last), .we(we),
        .wr_drop(wr_drop), .re(re), .wr_count(wc1), .rd_count(rc1),
        .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .wr_overflow(ov1), .dout_comb(dc1), .dout(do1), .dout_last(dl1));

    sync_fifo_pkt #(.DWIDTH(16), .AWIDTH(4), .PKT_MODE(0)) dut0 (
        .clk(clk), .arst(arst), .din(din), .din_last(din_last), .we(we),
        .wr_drop(wr_drop), .re(re), .wr_count(wc0), .rd_count(rc0),
        .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
        .wr_overflow(ov0), .dout_comb(dc0), .dout(do0), .dout_last(dl0));

    // Selected DUT view: m_mode picks which instance the model follows.
    bit          m_mode = 1'b1;
    logic [4:0]  o_wc, o_rc;
    logic        o_full, o_empty, o_af, o_ae, o_ov, o_dl;
    logic [15:0] o_dc, o_do;
    always_comb begin
        o_wc = m_mode ? wc1 : wc0;       o_rc = m_mode ? rc1 : rc0;
        o_full = m_mode ? full1 : full0; o_empty = m_mode ? empty1 : empty0;
        o_af = m_mode ? af1 : af0;       o_ae = m_mode ? ae1 : ae0;
        o_ov = m_mode ? ov1 : ov0;       o_dl = m_mode ? dl1 : dl0;
        o_dc = m_mode ? dc1 : dc0;       o_do = m_mode ? do1 : do0;
    end

    int total = 0;
    int bad = 0;

    // Reference model: readable words and the in-flight packet as queues.
    logic [16:0] cq[$];
    logic [16:0] pq[$];
    logic [15:0] exp_dout = '0;
    logic        exp_last = 1'b0;
    logic        exp_ov = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int occ;
        occ = cq.size() + pq.size();
        chk("wr_count", 32'(o_wc), 32'(occ));
        chk("rd_count", 32'(o_rc), 32'(cq.size()));
        chk("full", 32'(o_full), 32'(occ == 16));
        chk("empty", 32'(o_empty), 32'(cq.size() == 0));
        chk("almost_full", 32'(o_af), 32'(occ >= 14));
        chk("almost_empty", 32'(o_ae), 32'(cq.size() <= 1));
        chk("wr_overflow", 32'(o_ov), 32'(exp_ov));
        chk("dout", 32'(o_do), 32'(exp_dout));
        chk("dout_last", 32'(o_dl), 32'(exp_last));
        if (cq.size() > 0)
            chk("dout_comb", 32'(o_dc), 32'(cq[0][15:0]));
    endtask

    task automatic step(input logic w, input logic l, input logic d,
                        input logic r, input logic [15:0] data);
        bit full_m, drop_e;
        logic [16:0] t;
        full_m = (cq.size() + pq.size()) == 16;
        drop_e = m_mode && d;
        we = w; din_last = l; wr_drop = d; re = r; din = data;
        @(posedge clk); #1;
        we = 1'b0; din_last = 1'b0; wr_drop = 1'b0; re = 1'b0;
        exp_ov = w && (full_m || drop_e);
        if (r && cq.size() > 0) begin
            t = cq.pop_front();
            exp_last = t[16];
            exp_dout = t[15:0];
        end
        if (w && !full_m && !drop_e) begin
            if (!m_mode) cq.push_back({l, data});
            else begin
                pq.push_back({l, data});
                if (l) begin
                    foreach (pq[i]) cq.push_back(pq[i]);
                    pq.delete();
                end
            end
        end
        if (drop_e) pq.delete();
        check_all();
    endtask

    task automatic model_reset();
        cq.delete(); pq.delete();
        exp_dout = '0; exp_last = 1'b0; exp_ov = 1'b0;
    endtask

    initial begin
        // reset state
        arst = 1'b1;
        repeat (2) @(posedge clk);
        #1 arst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check_all();

        // 3-word packet, then read it back
        step(1, 0, 0, 0, 16'hA0A0);
        step(1, 0, 0, 0, 16'hB1B1);
        chk("rd_before_last", 32'(o_rc), 32'd0);
        step(1, 1, 0, 0, 16'hC2C2);
        chk("rd_after_last", 32'(o_rc), 32'd3);
        step(0, 0, 0, 1, 16'h0);
        step(0, 0, 0, 1, 16'h0);
        step(0, 0, 0, 1, 16'h0);
        chk("pkt_last_C", {o_do, 15'd0, o_dl}, {16'hC2C2, 16'd1});

        // 5 uncommitted words dropped; next packet lands at the old cm_addr
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 16'h5500 + 16'(i));
        chk("pend_wc5", 32'(o_wc), 32'd5);
        step(1, 0, 1, 0, 16'hDEAD);
        chk("drop_ov", 32'(o_ov), 32'd1);
        step(1, 1, 0, 0, 16'h7777);
        step(0, 0, 0, 1, 16'h0);

        // full 16-word packet, overflow, drain
        for (int i = 0; i < 16; i++) step(1, i == 15, 0, 0, 16'h1000 + 16'(i));
        chk("full16_rd", 32'(o_rc), 32'd16);
        step(1, 0, 0, 0, 16'hBAD0);
        chk("ovf_wc", 32'(o_wc), 32'd16);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 16'h0);

        // read and commit in the same cycle
        step(1, 0, 0, 0, 16'h2000);
        step(1, 1, 0, 0, 16'h2001);
        step(1, 0, 0, 0, 16'h2002);
        step(1, 0, 0, 0, 16'h2003);
        step(1, 1, 0, 1, 16'h2004);
        chk("rd_commit_same", 32'(o_rc), 32'd4);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 16'h0);

        // 40 single-word packets with concurrent reads (wraps several times)
        for (int i = 0; i < 40; i++)
            step(1, 1, 0, ($urandom_range(0, 2) == 0), 16'($urandom));
        // mixed random traffic including drops
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, 16'($urandom));

        // async reset mid-packet with 3 readable words
        while (cq.size() > 0 || pq.size() > 0) begin
            step(0, 0, 1, 1, 16'h0);
        end
        step(1, 0, 0, 0, 16'h3000);
        step(1, 0, 0, 0, 16'h3001);
        step(1, 1, 0, 0, 16'h3002);
        step(1, 0, 0, 0, 16'h3003);
        chk("pre_rst_rd", 32'(o_rc), 32'd3);
        #2 arst = 1'b1;
        #1;
        chk("arst_wc", 32'(o_wc), 32'd0);
        chk("arst_rd", 32'(o_rc), 32'd0);
        chk("arst_empty", 32'(o_empty), 32'd1);
        @(posedge clk); #1 arst = 1'b0;
        model_reset();
        check_all();

        // plain FIFO mode
        m_mode = 1'b0;
        arst = 1'b1; #2 arst = 1'b0;
        model_reset();
        step(1, 0, 0, 0, 16'h4444);
        chk("m0_visible", 32'(o_rc), 32'd1);
        step(1, 1, 0, 1, 16'h4545);
        chk("m0_dout", 32'(o_do), 32'h4444);
        for (int i = 0; i < 80; i++)
            step($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, 1'b0,
                 $urandom_range(0, 1) == 1, 16'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
